regfile_wb_arbiter: RTL and testbench

//   Shares the single integer register-file write port between NUM_REQ writeback sources.

---
 rtl/regfile_wb_arbiter_if.sv | 27 ++
 rtl/regfile_wb_arbiter.sv | 65 ++++++
 tb/tb_regfile_wb_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request bus and register-file write port
interface regfile_wb_arbiter_if #(
  parameter int N       = 64,
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5
);
  localparam int GW = $clog2(NUM_REQ);
  logic                  rf_stall;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*N-1:0]  req_data;
  logic                  rf_we;
  logic [ADDR_W-1:0]     rf_waddr;
  logic [N-1:0]          rf_wdata;
  logic [GW-1:0]         grant_id;
  logic                  x0_drop;
  logic                  contention;
  modport slave (
    input  rf_stall, req_valid, req_addr, req_data,
    output req_ready, rf_we, rf_waddr, rf_wdata, grant_id, x0_drop, contention
  );
  modport master (
    output rf_stall, req_valid, req_addr, req_data,
    input  req_ready, rf_we, rf_waddr, rf_wdata, grant_id, x0_drop, contention
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbitration of writeback sources onto one register-file write port
module regfile_wb_arbiter #(
  parameter int N       = 64,
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5
) (
  input  logic clk,
  input  logic reset_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     g;
  logic              found;
  logic              take;
  logic [ADDR_W-1:0] g_addr;
  logic [N-1:0]      g_data;
  // Two passes: sources at or above rr_ptr first, then wrap to the lowest indices.
  always_comb begin
    g = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++)
      if (!found && bus.req_valid[j] && GW'(j) >= rr_ptr) begin
        found = 1'b1;
        g = GW'(j);
      end
    for (int j = 0; j < NUM_REQ; j++)
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        g = GW'(j);
      end
  end
  always_comb begin
    g_addr = '0;
    g_data = '0;
    for (int j = 0; j < NUM_REQ; j++)
      if (g == GW'(j)) begin
        g_addr = bus.req_addr[j*ADDR_W +: ADDR_W];
        g_data = bus.req_data[j*N +: N];
      end
  end
  assign take           = found && !bus.rf_stall && reset_n;
  assign bus.req_ready  = take ? NUM_REQ'(1) << g : '0;
  assign bus.contention = ($countones(bus.req_valid) > 1) && !bus.rf_stall;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      bus.grant_id <= '0;
      bus.x0_drop  <= 1'b0;
      rr_ptr       <= '0;
    end else if (take) begin
      bus.rf_we    <= |g_addr;
      bus.rf_waddr <= g_addr;
      bus.rf_wdata <= g_data;
      bus.grant_id <= g;
      bus.x0_drop  <= ~|g_addr;
      rr_ptr       <= (g == GW'(NUM_REQ-1)) ? '0 : g + 1'b1;
    end else begin
      bus.rf_we    <= 1'b0;
      bus.x0_drop  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for the writeback arbiter
module tb_regfile_wb_arbiter;
  localparam int N = 64, NR = 3, AW = 5;
  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [N-1:0]  d;
    logic [1:0]    id;
    logic          drop;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n;
  int checks = 0, failures = 0;
  int m_ptr = 0;
  exp_t q[$];
  regfile_wb_arbiter_if #(.N(N), .NUM_REQ(NR), .ADDR_W(AW)) bus ();
  regfile_wb_arbiter #(.N(N), .NUM_REQ(NR), .ADDR_W(AW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic set_src(input int s, input logic v, input logic [AW-1:0] a, input logic [N-1:0] d);
    bus.req_valid[s] = v;
    bus.req_addr[s*AW +: AW] = a;
    bus.req_data[s*N +: N] = d;
  endtask
  // Called just after a falling edge with inputs already driven; returns granted source or -1.
  task automatic step(output int gg);
    exp_t e, o;
    logic [NR-1:0] er;
    bit tk;
    gg = -1;
    #1;
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (m_ptr + i) % NR;
      if (gg < 0 && bus.req_valid[k]) gg = k;
    end
    tk = gg >= 0 && !bus.rf_stall;
    er = '0;
    if (tk) er[gg] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("contention", 64'(bus.contention), 64'($countones(bus.req_valid) > 1 && !bus.rf_stall));
    if (tk) begin
      e.a = bus.req_addr[gg*AW +: AW];
      e.d = bus.req_data[gg*N +: N];
      e.we = e.a != 0;
      e.drop = e.a == 0;
      e.id = 2'(gg);
      q.push_back(e);
      m_ptr = (gg == NR-1) ? 0 : gg + 1;
    end else gg = -1;
    @(posedge clk);
    #1;
    if (tk) begin
      o = q.pop_front();
      chk("rf_we", 64'(bus.rf_we), 64'(o.we));
      chk("rf_waddr", 64'(bus.rf_waddr), 64'(o.a));
      chk("rf_wdata", bus.rf_wdata, o.d);
      chk("grant_id", 64'(bus.grant_id), 64'(o.id));
      chk("x0_drop", 64'(bus.x0_drop), 64'(o.drop));
    end else begin
      chk("idle_we", 64'(bus.rf_we), 64'd0);
      chk("idle_drop", 64'(bus.x0_drop), 64'd0);
    end
    @(negedge clk);
  endtask
  initial begin
    int g;
    logic [2:0] hist [4];
    reset_n = 1'b0;
    bus.rf_stall = 1'b0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.req_valid = '1;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_we", 64'(bus.rf_we), 64'd0);
    chk("rst_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("rst_wdata", bus.rf_wdata, 64'd0);
    chk("rst_gid", 64'(bus.grant_id), 64'd0);
    chk("rst_drop", 64'(bus.x0_drop), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.req_valid = '0;
    set_src(1, 1'b1, 5'd7, 64'hDEAD_BEEF);
    step(g);
    chk("single_g", 64'(g), 64'd1);
    set_src(1, 1'b0, 5'd0, 64'd0);
    set_src(2, 1'b1, 5'd9, 64'h1234);
    step(g);
    set_src(0, 1'b1, 5'd1, 64'hA0);
    set_src(1, 1'b1, 5'd2, 64'hA1);
    set_src(2, 1'b1, 5'd3, 64'hA2);
    for (int c = 0; c < 4; c++) begin
      step(g);
      hist[c] = 3'(g);
    end
    chk("rr_seq", {52'd0, hist[0], hist[1], hist[2], hist[3]}, {52'd0, 3'd0, 3'd1, 3'd2, 3'd0});
    bus.req_valid = '0;
    set_src(0, 1'b1, 5'd0, 64'd5);
    step(g);
    chk("x0_g", 64'(g), 64'd0);
    set_src(0, 1'b0, 5'd0, 64'd0);
    step(g);
    set_src(2, 1'b1, 5'd17, 64'hCAFE);
    bus.rf_stall = 1'b1;
    for (int c = 0; c < 3; c++) step(g);
    bus.rf_stall = 1'b0;
    step(g);
    chk("stall_g", 64'(g), 64'd2);
    bus.req_valid = '0;
    set_src(1, 1'b1, 5'd11, 64'hBEEF);
    #1;
    chk("ar_ready", 64'(bus.req_ready), 64'd2);
    @(posedge clk);
    #1;
    chk("ar_we_pre", 64'(bus.rf_we), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_we_async", 64'(bus.rf_we), 64'd0);
    q.delete();
    m_ptr = 0;
    @(negedge clk);
    reset_n = 1'b1;
    set_src(0, 1'b1, 5'd4, 64'h40);
    set_src(1, 1'b1, 5'd5, 64'h50);
    set_src(2, 1'b1, 5'd6, 64'h60);
    step(g);
    chk("ar_first_g", 64'(g), 64'd0);
    for (int c = 0; c < 60; c++) begin
      for (int s = 0; s < NR; s++)
        if (!bus.req_valid[s] && $urandom_range(1, 0) == 1)
          set_src(s, 1'b1, 5'($urandom_range(31, 0) & ($urandom_range(3, 0) == 0 ? 0 : 31)),
                  {$urandom, $urandom});
      bus.rf_stall = $urandom_range(4, 0) == 0;
      step(g);
      if (g >= 0) bus.req_valid[g] = 1'b0;
    end
    chk("q_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
